gates_mux: RTL and testbench

GATES_MUX -- requirements
Module: gates_mux

---
 rtl/gates_mux.sv | 165 ++++++++++++++++
 tb/tb_gates_mux.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/gates_mux.sv
// gates_mux: seven two-input logic functions of (a1, b1), each built purely
// from 2:1 mux cells, with registered results and a one-cycle valid strobe.

// Single 2:1 mux cell; the only primitive the datapath is allowed to use.
module gates_mux_mux2 (
  input  logic s,
  input  logic d0,
  input  logic d1,
  output logic y
);

  // Select d1 when s is high, otherwise d0.
  always_comb begin
    y = 1'b0;
    if (s) begin
      y = d1;
    end else begin
      y = d0;
    end
  end

endmodule

module gates_mux (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic a1,
  input  logic b1,
  output logic out1,
  output logic out2,
  output logic out3,
  output logic out4,
  output logic out5,
  output logic out6,
  output logic out7,
  output logic vld
);

  // Combinational mux network results.
  logic nb_s;
  logic not_s;
  logic or_s;
  logic and_s;
  logic nand_s;
  logic nor_s;
  logic xor_s;
  logic xnor_s;

  // Registered outputs.
  logic out1_r;
  logic out2_r;
  logic out3_r;
  logic out4_r;
  logic out5_r;
  logic out6_r;
  logic out7_r;
  logic vld_r;

  // Inverted b1, shared by NAND, NOR, XOR and XNOR (select is b1 here).
  gates_mux_mux2 u_nb (
    .s  (b1),
    .d0 (1'b1),
    .d1 (1'b0),
    .y  (nb_s)
  );

  // NOT a1.
  gates_mux_mux2 u_not (
    .s  (a1),
    .d0 (1'b1),
    .d1 (1'b0),
    .y  (not_s)
  );

  // a1 OR b1: a1 high forces 1, otherwise pass b1.
  gates_mux_mux2 u_or (
    .s  (a1),
    .d0 (b1),
    .d1 (1'b1),
    .y  (or_s)
  );

  // a1 AND b1: a1 low forces 0, otherwise pass b1.
  gates_mux_mux2 u_and (
    .s  (a1),
    .d0 (1'b0),
    .d1 (b1),
    .y  (and_s)
  );

  // a1 NAND b1: a1 low forces 1, otherwise pass inverted b1.
  gates_mux_mux2 u_nand (
    .s  (a1),
    .d0 (1'b1),
    .d1 (nb_s),
    .y  (nand_s)
  );

  // a1 NOR b1: a1 high forces 0, otherwise pass inverted b1.
  gates_mux_mux2 u_nor (
    .s  (a1),
    .d0 (nb_s),
    .d1 (1'b0),
    .y  (nor_s)
  );

  // a1 XOR b1: a1 chooses between b1 and its inverse.
  gates_mux_mux2 u_xor (
    .s  (a1),
    .d0 (b1),
    .d1 (nb_s),
    .y  (xor_s)
  );

  // a1 XNOR b1: mirror of XOR with the data inputs swapped.
  gates_mux_mux2 u_xnor (
    .s  (a1),
    .d0 (nb_s),
    .d1 (b1),
    .y  (xnor_s)
  );

  // Capture mux results when en is high; hold them otherwise; vld marks a fresh capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_r <= 1'b0;
      out2_r <= 1'b0;
      out3_r <= 1'b0;
      out4_r <= 1'b0;
      out5_r <= 1'b0;
      out6_r <= 1'b0;
      out7_r <= 1'b0;
      vld_r  <= 1'b0;
    end else if (en) begin
      out1_r <= not_s;
      out2_r <= or_s;
      out3_r <= and_s;
      out4_r <= nand_s;
      out5_r <= nor_s;
      out6_r <= xor_s;
      out7_r <= xnor_s;
      vld_r  <= 1'b1;
    end else begin
      out1_r <= out1_r;
      out2_r <= out2_r;
      out3_r <= out3_r;
      out4_r <= out4_r;
      out5_r <= out5_r;
      out6_r <= out6_r;
      out7_r <= out7_r;
      vld_r  <= 1'b0;
    end
  end

  assign out1 = out1_r;
  assign out2 = out2_r;
  assign out3 = out3_r;
  assign out4 = out4_r;
  assign out5 = out5_r;
  assign out6 = out6_r;
  assign out7 = out7_r;
  assign vld  = vld_r;

endmodule

// File: tb/tb_gates_mux.sv
// Directed testbench for gates_mux with hand-computed truth-table rows.
module tb_gates_mux;

  logic clk;
  logic rst_n;
  logic en;
  logic a1;
  logic b1;
  logic out1, out2, out3, out4, out5, out6, out7, vld;

  int errors = 0;
  int checks = 0;

  // Rows are {out1..out7} for (a1,b1): NOT, OR, AND, NAND, NOR, XOR, XNOR.
  localparam logic [6:0] ROW00 = 7'b1001101;
  localparam logic [6:0] ROW01 = 7'b1101010;
  localparam logic [6:0] ROW10 = 7'b0101010;
  localparam logic [6:0] ROW11 = 7'b0110001;

  logic [6:0] rows [4];
  logic [7:0] obs;

  assign obs = {out1, out2, out3, out4, out5, out6, out7, vld};

  gates_mux dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .a1    (a1),
    .b1    (b1),
    .out1  (out1),
    .out2  (out2),
    .out3  (out3),
    .out4  (out4),
    .out5  (out5),
    .out6  (out6),
    .out7  (out7),
    .vld   (vld)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count a comparison and report it when observed differs from expected.
  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at time %0t", tag, got, exp, $time);
    end
  endtask

  // Complement relations between outputs, independent of the truth table.
  task automatic check_comp(input string tag);
    check_eq({tag, "_n4"}, {7'b0000000, out4}, {7'b0000000, ~out3});
    check_eq({tag, "_n5"}, {7'b0000000, out5}, {7'b0000000, ~out2});
    check_eq({tag, "_n7"}, {7'b0000000, out7}, {7'b0000000, ~out6});
  endtask

  initial begin
    rows[0] = ROW00;
    rows[1] = ROW01;
    rows[2] = ROW10;
    rows[3] = ROW11;

    // Reset held with en=1 and a1=b1=1: everything stays 0.
    rst_n = 1'b0;
    en    = 1'b1;
    a1    = 1'b1;
    b1    = 1'b1;
    #1;
    check_eq("rst_t0", obs, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("rst_clk", obs, 8'h00);
    end

    // Release reset, then sweep 00, 01, 10, 11 with en held high.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a1 = i[1];
      b1 = i[0];
      @(posedge clk);
      #1;
      check_eq($sformatf("sweep%0d", i), obs, {rows[i], 1'b1});
      check_comp($sformatf("sweep%0d", i));
    end

    // Drop en with new operands: outputs hold 11 result, vld falls.
    en = 1'b0;
    a1 = 1'b0;
    b1 = 1'b0;
    @(posedge clk);
    #1;
    check_eq("hold1", obs, {ROW11, 1'b0});
    @(posedge clk);
    #1;
    check_eq("hold2", obs, {ROW11, 1'b0});

    // Toggle operands between edges: outputs change only at rising edges.
    en = 1'b1;
    a1 = 1'b1;
    b1 = 1'b0;
    #2;
    check_eq("mid_a", obs, {ROW11, 1'b0});
    a1 = 1'b0;
    b1 = 1'b1;
    #1;
    check_eq("mid_b", obs, {ROW11, 1'b0});
    a1 = 1'b0;
    b1 = 1'b0;
    @(posedge clk);
    #1;
    check_eq("edge00", obs, {ROW00, 1'b1});
    check_comp("edge00");
    a1 = 1'b1;
    b1 = 1'b1;
    #2;
    check_eq("mid_c", obs, {ROW00, 1'b1});
    a1 = 1'b1;
    b1 = 1'b0;
    #1;
    check_eq("mid_d", obs, {ROW00, 1'b1});
    a1 = 1'b0;
    b1 = 1'b1;
    @(posedge clk);
    #1;
    check_eq("edge01", obs, {ROW01, 1'b1});
    check_comp("edge01");

    // Mid-cycle reset after capturing 01: outputs clear without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst", obs, 8'h00);
    @(posedge clk);
    #1;
    check_eq("rst_en_ign", obs, 8'h00);

    // After release, no capture until en is high.
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst_idle", obs, 8'h00);
    en = 1'b1;
    a1 = 1'b1;
    b1 = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst_cap", obs, {ROW10, 1'b1});
    check_comp("post_rst_cap");
    en = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst_hold", obs, {ROW10, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
